// File: rtl/alu_pkg.sv
// Shared ALU control definitions: ALUControl codes, ALUOp/funct3 values, issue FSM states.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7[5] to ALUControl decode; shared with the single-cycle control unit.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0]            aluop,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] ctrl_c,
  output logic                  illegal_c
);

  always_comb begin
    ctrl_c    = ALU_ADD;
    illegal_c = 1'b0;
    case (aluop)
      ALUOP_MEM:    ctrl_c = ALU_ADD;
      ALUOP_BRANCH: ctrl_c = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADDSUB: ctrl_c = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:    ctrl_c = ALU_AND;
          F3_OR:     ctrl_c = ALU_OR;
          default:   illegal_c = 1'b1;
        endcase
      end
      ALUOP_RSVD:   illegal_c = 1'b1;
      default:      illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded operation to the 64-bit ALU, holds its inputs for a settle time,
// and returns the captured result over a valid/ready response channel.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_aluop,
  input  logic [2:0]            req_funct3,
  input  logic                  req_funct7b5,
  input  logic [XLEN-1:0]       req_a,
  input  logic [XLEN-1:0]       req_b,
  output logic [XLEN-1:0]       alu_x,
  output logic [XLEN-1:0]       alu_y,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_cout,
  output logic                  rsp_err,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [SET_W-1:0]        settle_q, settle_d;
  logic [XLEN-1:0]         alu_x_d, alu_y_d, rsp_result_d;
  logic [ALU_CTRL_W-1:0]   alu_ctrl_d;
  logic                    rsp_zero_d, rsp_cout_d, rsp_err_d;
  logic [CNT_W-1:0]        ops_done_d;
  logic [ALU_CTRL_W-1:0]   dec_ctrl;
  logic                    dec_illegal;

  alu_op_decode u_dec (
    .aluop     (req_aluop),
    .funct3    (req_funct3),
    .funct7b5  (req_funct7b5),
    .ctrl_c    (dec_ctrl),
    .illegal_c (dec_illegal)
  );

  // Ready is a pure state decode, forced low while reset is held.
  assign req_ready = rst_n & (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    alu_x_d      = alu_x;
    alu_y_d      = alu_y;
    alu_ctrl_d   = alu_ctrl;
    rsp_result_d = rsp_result;
    rsp_zero_d   = rsp_zero;
    rsp_cout_d   = rsp_cout;
    rsp_err_d    = rsp_err;
    ops_done_d   = ops_done;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_illegal) begin
            // Illegal ops never touch the ALU inputs; answer immediately.
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_cout_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end else begin
            alu_x_d    = req_a;
            alu_y_d    = req_b;
            alu_ctrl_d = dec_ctrl;
            settle_d   = SET_W'(SETTLE_CYCLES - 1);
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SET_W'(1);
        end else begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_cout_d   = alu_cout;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done + CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q   <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_ctrl   <= ALU_CTRL_W'(0);
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      settle_q   <= settle_d;
      alu_x      <= alu_x_d;
      alu_y      <= alu_y_d;
      alu_ctrl   <= alu_ctrl_d;
      rsp_result <= rsp_result_d;
      rsp_zero   <= rsp_zero_d;
      rsp_cout   <= rsp_cout_d;
      rsp_err    <= rsp_err_d;
      ops_done   <= ops_done_d;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Control-side initiator for the 64-bit ALU (ports x, y, ALUControl, cout, zero, result) in the single-cycle RISC-V datapath.
- Accepts an operation request over a valid/ready handshake.
- Decodes ALUOp/funct3/funct7[5] into the 4-bit ALUControl code and drives registered operands into the ALU.
- Waits a programmable settle time, captures result/zero/cout, and returns them over a valid/ready response channel.
- Counts completed operations.

Parameters:
XLEN, 64, operand/result width; must match the ALU.
SETTLE_CYCLES, 1, clock cycles the ALU inputs are held before capture; legal values are >= 1.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE.
req_aluop  input  2  00 = load/store, 01 = branch, 10 = R-type, 11 = reserved.
req_funct3  input  3  instruction funct3.
req_funct7b5  input  1  instruction bit 30.
req_a  input  XLEN  operand A.
req_b  input  XLEN  operand B.
alu_x  output  XLEN  registered operand to ALU x.
alu_y  output  XLEN  registered operand to ALU y.
alu_ctrl  output  4  registered ALUControl to the ALU.
alu_result  input  XLEN  ALU result.
alu_zero  input  1  ALU zero flag.
alu_cout  input  1  ALU carry-out.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  XLEN  captured result.
rsp_zero  output  1  captured zero flag.
rsp_cout  output  1  captured carry-out.
rsp_err  output  1  illegal decode.
ops_done  output  CNT_W  count of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - alu_x, alu_y, rsp_result, ops_done = 0.
  - alu_ctrl = 4'b0000.
  - rsp_valid, rsp_zero, rsp_cout, rsp_err = 0.
  - req_ready = 0 while rst_n=0 and 1 after release.
- ALUControl encoding: ADD = 0010, SUB = 0110, AND = 0000, OR = 0001.
- Decode:
  - aluop 00 -> ADD.
  - aluop 01 -> SUB.
  - aluop 10 with funct3 000, f7b5 = 0 -> ADD.
  - aluop 10 with funct3 000, f7b5 = 1 -> SUB.
  - aluop 10 with funct3 111 -> AND.
  - aluop 10 with funct3 110 -> OR.
  - Any other combination is ILLEGAL.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: req_ready = 1. On req_valid, the transfer happens at that edge.
    - Legal op: latch req_a -> alu_x, req_b -> alu_y, decoded code -> alu_ctrl; load the settle counter with SETTLE_CYCLES-1; go to ISSUE.
    - ILLEGAL: alu_x, alu_y, alu_ctrl are unchanged; rsp_result = 0, rsp_zero = 0, rsp_cout = 0, rsp_err = 1; go to RESP directly.
  - ISSUE: req_ready = 0; ALU inputs are held stable.
    - Counter != 0: decrement.
    - Counter == 0: capture alu_result, alu_zero, alu_cout into the rsp_* registers; rsp_err = 0; go to RESP.
  - RESP: rsp_valid = 1; all rsp_* outputs are stable until the handshake completes.
    - On rsp_ready: go to IDLE and increment ops_done at the same edge.
    - rsp_ready held low: remain in RESP indefinitely.
- Latency, legal op: rsp_valid rises SETTLE_CYCLES edges after the accepting edge.
- Latency, illegal op: rsp_valid rises at the accepting edge.
- Throughput: no bypass. After the response handshake, req_ready is 1 in the next cycle. Minimum spacing between accepts is SETTLE_CYCLES+2 edges for legal ops.
- req_valid outside IDLE is ignored; the requester must hold its request.
- alu_x, alu_y, alu_ctrl keep their last values in IDLE and RESP. The ALU is never glitched mid-operation.
- ops_done wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-ISSUE or mid-RESP:
  - The operation is dropped with no response.
  - ops_done clears to 0.

Decomposition:
- Shared package alu_pkg holds:
  - ALUControl constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR.
  - ALUOp constants.
  - The funct3 constants.
  - The FSM state enum.
- One natural sub-module, alu_op_decode: combinational decode of aluop/funct3/f7b5 to {ctrl[3:0], illegal}. The same decoder is reusable by the single-cycle control unit.

Test Plan:
All scenarios use alu_issue_ctrl connected to the real ALU, SETTLE_CYCLES = 1 unless noted.
- aluop=00, a=1, b=0 -> alu_ctrl=0010; one edge later rsp_valid=1, rsp_result=1, rsp_zero=0, rsp_err=0; ops_done=1 after the handshake.
- aluop=10, funct3=000, f7b5=1, a=6, b=3 -> alu_ctrl=0110, rsp_result=3, rsp_zero=0. Repeat with a=b=5 -> rsp_result=0, rsp_zero=1.
- aluop=10, funct3=111, a=6, b=1 -> alu_ctrl=0000, rsp_result=0, rsp_zero=1. Then funct3=110, a=6, b=3 -> alu_ctrl=0001, rsp_result=7.
- Illegal request aluop=11 or aluop=10 with funct3=001 -> rsp_valid at the accepting edge, rsp_err=1, rsp_result=0, alu_ctrl unchanged from the prior op.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, a new req_valid is not accepted. Release rsp_ready -> IDLE next cycle. Run with SETTLE_CYCLES=3 and check rsp_valid occurs 3 edges after accept.
- Pull rst_n low mid-ISSUE -> outputs zero immediately (asynchronously), no response, ops_done=0. Preset ops_done near 2^CNT_W-1 (via CNT_W=2, 4 ops) -> wraps to 0.
